// File: rtl/mem_store_buffer_if.sv
// rtl/mem_store_buffer_if.sv - MEM-stage and data-memory signals of the posted-store buffer
interface mem_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic [31:0]   st_pc;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [31:0]   dm_rdata;
  logic [31:0]   ld_word;
  logic          stall;
  logic [31:0]   dm_addr;
  logic          dm_en;
  logic [31:0]   dm_wdata;
  logic [1:0]    dm_savesel;
  logic [31:0]   dm_pc8;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, st_size, st_pc, ld_valid, ld_addr, dm_rdata,
    input  ld_word, stall, dm_addr, dm_en, dm_wdata, dm_savesel, dm_pc8, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, st_pc, ld_valid, ld_addr, dm_rdata,
    output ld_word, stall, dm_addr, dm_en, dm_wdata, dm_savesel, dm_pc8, count
  );
endinterface

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - posted-store FIFO with byte-merging load forwarding
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          drain;
  logic          accept;
  logic [31:0]   merged;
  entry_t        slot;

  function automatic logic [31:0] merge_entry(input logic [31:0] base, input entry_t e);
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] r;
    case (e.size)
      2'd1: begin
        be    = 4'b0011 << {e.addr[1], 1'b0};
        lanes = {2{e.data[15:0]}};
      end
      2'd2: begin
        be    = 4'b0001 << e.addr[1:0];
        lanes = {4{e.data[7:0]}};
      end
      default: begin
        be    = 4'b1111;
        lanes = e.data;
      end
    endcase
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = lanes[8*b +: 8];
    end
    return r;
  endfunction

  // Loads own the DM port; stores only retire in cycles without a load.
  assign drain  = (count != '0) && !bus.ld_valid;
  assign accept = bus.st_valid && ((count < CW'(DEPTH)) || drain);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[tail] <= '{addr: bus.st_addr,
                       data: bus.st_data,
                       size: (bus.st_size == 2'd3) ? 2'd0 : bus.st_size,
                       pc:   bus.st_pc};
        tail <= tail + PW'(1);
      end
      if (drain) head <= head + PW'(1);
      count <= count + CW'(accept) - CW'(drain);
    end
  end

  // Walk oldest to youngest so the youngest matching store overwrites each byte last.
  always_comb begin
    merged = bus.dm_rdata;
    slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        slot = mem[head + PW'(i)];
        if (slot.addr[31:2] == bus.ld_addr[31:2]) merged = merge_entry(merged, slot);
      end
    end
  end

  assign bus.ld_word    = reset ? bus.dm_rdata : merged;
  assign bus.stall      = bus.st_valid && !accept && !reset;
  assign bus.dm_en      = drain && !reset;
  assign bus.dm_addr    = bus.ld_valid ? bus.ld_addr : mem[head].addr;
  assign bus.dm_wdata   = mem[head].data;
  assign bus.dm_savesel = mem[head].size;
  assign bus.dm_pc8     = mem[head].pc + 32'd8;
  assign bus.count      = count;
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - scoreboard bench for the posted-store buffer
module tb_mem_store_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_store_buffer_if #(.DEPTH(4)) bus ();

  mem_store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sel;
    logic [31:0] pc8;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] lq[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input logic [31:0] p);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.sel  = s;
    e.pc8  = p + 32'd8;
    wq.push_back(e);
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] ss, input logic [31:0] sp, input logic lv,
                       input logic [31:0] la, input logic [31:0] rd);
    @(posedge clk);
    #1;
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.st_size  = ss;
    bus.st_pc    = sp;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    bus.dm_rdata = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: every DM write and every pure load is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dm_en) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dm_write actual_addr=%h required=none", bus.dm_addr);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", bus.dm_addr, e.addr);
          check("wr_data", bus.dm_wdata, e.data);
          check("wr_savesel", 32'(bus.dm_savesel), 32'(e.sel));
          check("wr_pc8", bus.dm_pc8, e.pc8);
        end
      end
      if (bus.ld_valid && !bus.st_valid) begin
        if (lq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load actual=%h required=none", bus.ld_word);
        end else begin
          check("ld_word", bus.ld_word, lq.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_size  = '0;
    bus.st_pc    = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.dm_rdata = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dm_en", 32'(bus.dm_en), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_ld_word", bus.ld_word, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single word store retires the next cycle
    push_wr(32'h10, 32'h12345678, 2'd0, 32'h100);
    drive(1'b1, 32'h10, 32'h12345678, 2'd0, 32'h100, 1'b0, 32'h0, 32'h0);
    check("t1_count_issue", 32'(bus.count), 32'd0);
    check("t1_dm_en_issue", 32'(bus.dm_en), 32'd0);
    idle();
    check("t1_dm_en", 32'(bus.dm_en), 32'd1);
    check("t1_count_1", 32'(bus.count), 32'd1);
    idle();
    check("t1_count_0", 32'(bus.count), 32'd0);

    // fill while loads block the port, then stall, then accept+drain together
    for (int i = 0; i < 4; i++) begin
      push_wr(32'h40 + 32'(4 * i), 32'h40400000 + 32'(i), 2'd0, 32'h200 + 32'(4 * i));
      drive(1'b1, 32'h40 + 32'(4 * i), 32'h40400000 + 32'(i), 2'd0, 32'h200 + 32'(4 * i),
            1'b1, 32'h80, 32'h0);
    end
    drive(1'b1, 32'h50, 32'h40400004, 2'd0, 32'h210, 1'b1, 32'h80, 32'h0);
    check("t2_count_full", 32'(bus.count), 32'd4);
    check("t2_stall", 32'(bus.stall), 32'd1);
    push_wr(32'h50, 32'h40400004, 2'd0, 32'h210);
    drive(1'b1, 32'h50, 32'h40400004, 2'd0, 32'h210, 1'b0, 32'h0, 32'h0);
    check("t2_stall_clear", 32'(bus.stall), 32'd0);
    check("t2_dm_en", 32'(bus.dm_en), 32'd1);
    idle();
    check("t2_count_held", 32'(bus.count), 32'd4);
    repeat (4) idle();
    check("t2_count_drained", 32'(bus.count), 32'd0);

    // byte merge and youngest-wins over a buffered word
    push_wr(32'h20, 32'hAABBCCDD, 2'd0, 32'h300);
    drive(1'b1, 32'h20, 32'hAABBCCDD, 2'd0, 32'h300, 1'b0, 32'h0, 32'h0);
    push_wr(32'h21, 32'h00000011, 2'd2, 32'h304);
    drive(1'b1, 32'h21, 32'h00000011, 2'd2, 32'h304, 1'b1, 32'h20, 32'h0);
    lq.push_back(32'hAABB11DD);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h20, 32'h0);
    push_wr(32'h21, 32'h00000077, 2'd2, 32'h308);
    drive(1'b1, 32'h21, 32'h00000077, 2'd2, 32'h308, 1'b1, 32'h20, 32'h0);
    lq.push_back(32'hAABB77DD);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h20, 32'h0);
    repeat (4) idle();

    // halfword in upper lanes merged over DM data
    push_wr(32'h32, 32'h1234BEEF, 2'd1, 32'h400);
    drive(1'b1, 32'h32, 32'h1234BEEF, 2'd1, 32'h400, 1'b0, 32'h0, 32'h0);
    lq.push_back(32'hBEEF0304);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h30, 32'h01020304);
    repeat (2) idle();

    // pointer wrap with interleaved hit and miss loads
    for (int k = 0; k < 10; k++) begin
      push_wr(32'h100 + 32'(4 * k), 32'hD0000000 + 32'(k), 2'd0, 32'h500 + 32'(4 * k));
      drive(1'b1, 32'h100 + 32'(4 * k), 32'hD0000000 + 32'(k), 2'd0, 32'h500 + 32'(4 * k),
            1'b0, 32'h0, 32'h0);
      check("t5_count_bound", 32'(bus.count <= 3'd4), 32'd1);
      if (k % 2 == 1) begin
        lq.push_back(32'hD0000000 + 32'(k));
        drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h100 + 32'(4 * k), 32'h0);
        lq.push_back(32'h5A5A5A5A);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h600, 32'h5A5A5A5A);
        check("t5_count_bound_ld", 32'(bus.count <= 3'd4), 32'd1);
      end
    end
    repeat (6) idle();
    check("t5_count_drained", 32'(bus.count), 32'd0);

    // reset discards buffered stores
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(4 * i), 32'h000000EE, 2'd0, 32'h700, 1'b1, 32'h900, 32'h0);
    end
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    check("t6_count_pre", 32'(bus.count), 32'd3);
    check("t6_dm_en_rst", 32'(bus.dm_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_count_post", 32'(bus.count), 32'd0);
    check("t6_dm_en_post", 32'(bus.dm_en), 32'd0);
    repeat (4) idle();

    check("wr_queue_empty", 32'(wq.size()), 32'd0);
    check("ld_queue_empty", 32'(lq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
